// File: rtl/boot_loader_ctrl_if.sv
// Bus bundle for boot_loader_ctrl: UART byte stream and reload request in,
// instruction-memory write port and pipeline status out.
interface boot_loader_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  i_rx_valid;
    logic [7:0]            i_rx_data;
    logic                  i_reload;
    logic                  o_imem_we;
    logic [ADDR_WIDTH-1:0] o_imem_addr;
    logic [31:0]           o_imem_wdata;
    logic                  o_cpu_rst;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    modport master (
        output i_rx_valid, i_rx_data, i_reload,
        input  o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_rst, o_busy, o_done, o_err
    );

    modport slave (
        input  i_rx_valid, i_rx_data, i_reload,
        output o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_rst, o_busy, o_done, o_err
    );
endinterface

// File: rtl/boot_loader_ctrl.sv
// UART boot controller: receives a framed program image, writes it word by word
// into instruction memory, then releases the pipeline from reset.
module boot_loader_ctrl #(
    parameter int         ADDR_WIDTH     = 10,
    parameter logic [7:0] START_BYTE     = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input logic               clk,
    input logic               rst_n,
    boot_loader_ctrl_if.slave bus
);
    localparam int MAX_WORDS = 2 ** ADDR_WIDTH;
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, RUN} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [7:0]          r_lenLo;
    logic [15:0]         r_len;
    logic [31:0]         r_wdata;
    logic [1:0]          r_byteIdx;
    logic [ADDR_WIDTH:0] r_wordIdx;
    logic [TW-1:0]       r_timeout;
    logic                r_err;

    logic [15:0]         w_lenFull;
    logic [ADDR_WIDTH:0] w_wordNext;
    logic                w_active;
    logic                w_timedOut;
    logic                w_lastWord;
    logic                w_capture;
    logic                w_startData;
    logic                w_setErr;
    logic                w_clrErr;

    assign w_lenFull  = {bus.i_rx_data, r_lenLo};
    assign w_wordNext = r_wordIdx + 1'b1;
    assign w_lastWord = (16'(w_wordNext) == r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_startData = 1'b0;
        w_setErr    = 1'b0;
        w_clrErr    = 1'b0;
        w_active    = (r_state == LEN0) || (r_state == LEN1) || (r_state == DATA);
        w_timedOut  = w_active && !bus.i_rx_valid && (r_timeout == TW'(TIMEOUT_CYCLES - 1));

        case (r_state)
            IDLE: begin
                if (bus.i_rx_valid && (bus.i_rx_data == START_BYTE)) begin
                    w_nextState = LEN0;
                    w_clrErr    = 1'b1;
                end
            end
            LEN0: begin
                if (bus.i_rx_valid) w_nextState = LEN1;
            end
            LEN1: begin
                if (bus.i_rx_valid) begin
                    if (w_lenFull == 16'd0) begin
                        w_nextState = RUN;
                    end else if (int'(w_lenFull) > MAX_WORDS) begin
                        w_nextState = IDLE;
                        w_setErr    = 1'b1;
                    end else begin
                        w_nextState = DATA;
                        w_startData = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.i_rx_valid) begin
                    w_capture = 1'b1;
                    if (r_byteIdx == 2'd3) w_nextState = WRITE;
                end
            end
            // A byte landing during the write cycle already belongs to the next word
            WRITE: begin
                w_nextState = w_lastWord ? RUN : DATA;
                w_capture   = bus.i_rx_valid && !w_lastWord;
            end
            RUN: begin
                if (bus.i_reload) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase

        if (w_timedOut) begin
            w_nextState = IDLE;
            w_setErr    = 1'b1;
        end

        bus.o_imem_we    = (r_state == WRITE);
        bus.o_imem_addr  = r_wordIdx[ADDR_WIDTH-1:0];
        bus.o_imem_wdata = r_wdata;
        bus.o_cpu_rst    = (r_state != RUN);
        bus.o_done       = (r_state == RUN);
        bus.o_busy       = w_active || (r_state == WRITE);
        bus.o_err        = r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lenLo   <= '0;
            r_len     <= '0;
            r_wdata   <= '0;
            r_byteIdx <= '0;
            r_wordIdx <= '0;
            r_timeout <= '0;
            r_err     <= 1'b0;
        end else begin
            if (bus.i_rx_valid && (r_state == LEN0)) r_lenLo <= bus.i_rx_data;
            if (bus.i_rx_valid && (r_state == LEN1)) r_len   <= w_lenFull;
            if (w_startData) begin
                r_wordIdx <= '0;
                r_byteIdx <= '0;
            end
            if (w_capture) begin
                r_wdata[8*r_byteIdx +: 8] <= bus.i_rx_data;
                r_byteIdx                 <= r_byteIdx + 1'b1;
            end
            if (r_state == WRITE) r_wordIdx <= w_wordNext;
            if (w_setErr) begin
                r_err <= 1'b1;
            end else if (w_clrErr) begin
                r_err <= 1'b0;
            end
            // Idle time is only measured while a frame is in flight
            if (!w_active || bus.i_rx_valid || w_timedOut) begin
                r_timeout <= '0;
            end else begin
                r_timeout <= r_timeout + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: directed frames plus random images,
// imem writes checked against a frame-level reference model.
module tb_boot_loader_ctrl;
    localparam int AW   = 4;
    localparam int TO   = 16;
    localparam int MAXW = 2 ** AW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    wr_t  expQ[$];
    logic modelRun = 1'b0;

    boot_loader_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    boot_loader_ctrl #(
        .ADDR_WIDTH(AW),
        .START_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of run, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input logic cpuRst, input logic done,
                               input logic busy, input logic err);
        checkOutput({tag, ".cpu_rst"}, 32'(bus.o_cpu_rst), 32'(cpuRst));
        checkOutput({tag, ".done"},    32'(bus.o_done),    32'(done));
        checkOutput({tag, ".busy"},    32'(bus.o_busy),    32'(busy));
        checkOutput({tag, ".err"},     32'(bus.o_err),     32'(err));
    endtask

    task automatic checkResetValues(input string tag);
        checkStatus(tag, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, ".imem_we"},    32'(bus.o_imem_we),   32'd0);
        checkOutput({tag, ".imem_addr"},  32'(bus.o_imem_addr), 32'd0);
        checkOutput({tag, ".imem_wdata"}, bus.o_imem_wdata,     32'd0);
    endtask

    // Called at posedge+1; presents one byte for exactly one cycle, then idles gap cycles
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic applyReload(input logic withByte);
        bus.i_reload   = 1'b1;
        bus.i_rx_valid = withByte;
        bus.i_rx_data  = 8'hA5;
        @(posedge clk); #1;
        bus.i_reload   = 1'b0;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic pushWrite(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = AW'(addr);
        e.data = data;
        expQ.push_back(e);
    endtask

    // Monitor: every imem write must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && bus.o_imem_we === 1'b1) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h, expected no write",
                         bus.o_imem_addr, bus.o_imem_wdata);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("writeAddr", 32'(bus.o_imem_addr), 32'(e.addr));
                checkOutput("writeData", bus.o_imem_wdata, e.data);
            end
        end
    end

    initial begin
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_reload   = 1'b0;

        // Reset and idle: nothing but dropped bytes, pipeline held
        #12;
        checkResetValues("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        idleCycles(5);
        checkStatus("idle", 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h13, 0);
        applyStimulus(8'h5A, 1);
        applyStimulus(8'hFF, 1);
        checkStatus("idleDrop", 1'b1, 1'b0, 1'b0, 1'b0);

        // Two-word image, second word arrives back-to-back through the write cycle
        pushWrite(0, 32'h0000_0013);
        pushWrite(1, 32'h0010_0093);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h13, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        checkOutput("twoWord.weFirst", 32'(bus.o_imem_we), 32'd1);
        applyStimulus(8'h93, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h10, 0);
        applyStimulus(8'h00, 0);
        checkStatus("twoWord.lastWrite", 1'b1, 1'b0, 1'b1, 1'b0);
        idleCycles(1);
        checkStatus("twoWord.run", 1'b0, 1'b1, 1'b0, 1'b0);

        // Reload with a simultaneous byte: reload wins and the byte is dropped
        applyReload(1'b1);
        checkStatus("reload", 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(2);
        checkStatus("reloadByteDropped", 1'b1, 1'b0, 1'b0, 1'b0);

        // Zero-length image goes straight to RUN
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        checkStatus("zeroLen", 1'b0, 1'b1, 1'b0, 1'b0);
        applyReload(1'b0);
        checkStatus("zeroLenReload", 1'b1, 1'b0, 1'b0, 1'b0);

        // Length one beyond capacity
        applyStimulus(8'hA5, 0);
        applyStimulus(8'(MAXW + 1), 0);
        applyStimulus(8'h00, 0);
        checkStatus("badLen", 1'b1, 1'b0, 1'b0, 1'b1);
        idleCycles(3);
        checkStatus("badLenSticky", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hA5, 0);
        checkStatus("errCleared", 1'b1, 1'b0, 1'b1, 1'b0);

        // Inter-byte timeout mid-word: partial word is never written
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hAA, 0);
        idleCycles(8);
        checkStatus("timeoutWaiting", 1'b1, 1'b0, 1'b1, 1'b0);
        idleCycles(8);
        checkStatus("timeout", 1'b1, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a word
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        checkStatus("midData", 1'b1, 1'b0, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetValues("asyncReset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random images against the frame-level model
        for (int iter = 0; iter < 24; iter++) begin
            int          len;
            int          sel;
            logic [31:0] w;
            logic        badLen;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      len = 0;
            else if (sel == 1) len = int'($urandom_range(MAXW + 1, 300));
            else               len = int'($urandom_range(1, MAXW));
            badLen = (len > MAXW);
            if (modelRun) begin
                applyReload(1'b0);
                idleCycles(int'($urandom_range(0, 2)));
            end else begin
                w = $urandom;
                applyStimulus((w[7:0] == 8'hA5) ? 8'h00 : w[7:0], int'($urandom_range(0, 2)));
            end
            applyStimulus(8'hA5, int'($urandom_range(0, 3)));
            applyStimulus(8'(len), int'($urandom_range(0, 3)));
            applyStimulus(8'(len >> 8), int'($urandom_range(0, 3)));
            if (!badLen) begin
                for (int i = 0; i < len; i++) begin
                    w = $urandom;
                    pushWrite(i, w);
                    for (int k = 0; k < 4; k++) begin
                        applyStimulus(w[8*k +: 8], int'($urandom_range(0, 3)));
                    end
                end
            end
            idleCycles(2);
            if (badLen) checkStatus("randBadLen", 1'b1, 1'b0, 1'b0, 1'b1);
            else        checkStatus("randRun",    1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("randDrained", 32'(expQ.size()), 32'd0);
            modelRun = !badLen;
        end

        idleCycles(3);
        checkOutput("finalDrained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
